// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU/forward/result encodings and the ID/EX pipeline register payload.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             alu_src;
    logic [2:0]       alu_control;
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
  } id_ex_t;

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding select for one source register; EX/MEM beats MEM/WB, x0 never forwards.
module forward_mux
  import riscv_pkg::*;
(
  input  logic [4:0]  rs,
  input  logic [31:0] reg_data,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_data,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] data,
  output logic [1:0]  sel
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs);
  assign memwb_hit = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs);

  always_comb begin
    data = reg_data;
    sel  = FWD_REG;
    if (exmem_hit) begin
      data = exmem_data;
      sel  = FWD_EXMEM;
    end else if (memwb_hit) begin
      data = memwb_data;
      sel  = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall control and RAW forwarding into the ALU operands.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_alu_src,
  input  logic [2:0]  id_alu_control,
  input  logic        id_reg_write,
  input  logic        id_mem_write,
  input  logic [1:0]  id_result_src,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_alu_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [1:0]  ex_result_src,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_store_data,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
);

  id_ex_t      ex_q;
  id_ex_t      ex_d;
  logic [31:0] rs2_fwd;

  // Next register value: flush beats stall; an invalid slot never writes.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rs1_data    = id_rs1_data;
      ex_d.rs2_data    = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.alu_src     = id_alu_src;
      ex_d.alu_control = id_alu_control;
      ex_d.reg_write   = id_valid & id_reg_write;
      ex_d.mem_write   = id_valid & id_mem_write;
      ex_d.result_src  = id_result_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  forward_mux u_fwd_rs1 (
    .rs              (ex_q.rs1),
    .reg_data        (ex_q.rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_data      (exmem_alu_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_result),
    .data            (alu_a),
    .sel             (fwd_a)
  );

  forward_mux u_fwd_rs2 (
    .rs              (ex_q.rs2),
    .reg_data        (ex_q.rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_data      (exmem_alu_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_result),
    .data            (rs2_fwd),
    .sel             (fwd_b)
  );

  // Store data always follows rs2 forwarding, independent of the immediate select.
  assign alu_b         = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_control   = ex_q.alu_control;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_result_src = ex_q.result_src;
  assign ex_pc         = ex_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, x0, immediate, stall/flush, async reset.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_write;
  logic [1:0]  id_result_src;
  logic        stall, flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_control;
  logic        ex_valid, ex_reg_write, ex_mem_write;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [1:0]  ex_result_src;
  logic [31:0] ex_pc, ex_store_data;
  logic [1:0]  fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_result_src(id_result_src),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_result_src(ex_result_src),
    .ex_pc(ex_pc), .ex_store_data(ex_store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic src,
                          input logic [2:0] ctl, input logic rw, input logic mw,
                          input logic [1:0] rsrc);
    id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_src = src; id_alu_control = ctl;
    id_reg_write = rw; id_mem_write = mw; id_result_src = rsrc;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_alu_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    drive_id(1'b1, 32'h40, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 1'b0, 3'b011, 1'b1, 1'b1, 2'b01);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
    checks++; if (alu_control !== 3'b000) begin errors++; $display("FAIL reset_alu_control: got %b expected 000", alu_control); end
    checks++; if (ex_pc !== 32'd0 || ex_rd !== 5'd0 || ex_rs1 !== 5'd0 || ex_rs2 !== 5'd0) begin errors++; $display("FAIL reset_fields: pc %h rd %0d rs1 %0d rs2 %0d expected all 0", ex_pc, ex_rd, ex_rs1, ex_rs2); end
    checks++; if (ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin errors++; $display("FAIL reset_writes: got rw %b mw %b expected 0 0", ex_reg_write, ex_mem_write); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_operands: a %h b %h fa %b fb %b expected 0", alu_a, alu_b, fwd_a, fwd_b); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive_id(1'b1, 32'h100, 32'd5, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b001, 1'b1, 1'b0, 2'b10);
    tick();
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin errors++; $display("FAIL basic_operands: got a %h b %h expected 5 3", alu_a, alu_b); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL basic_fwd: got %b %b expected 00 00", fwd_a, fwd_b); end
    checks++; if (ex_valid !== 1'b1 || alu_control !== 3'b001 || ex_pc !== 32'h100) begin errors++; $display("FAIL basic_ctrl: valid %b ctl %b pc %h expected 1 001 100", ex_valid, alu_control, ex_pc); end
    checks++; if (ex_rd !== 5'd3 || ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2 || ex_reg_write !== 1'b1 || ex_result_src !== 2'b10) begin errors++; $display("FAIL basic_fields: rd %0d rs1 %0d rs2 %0d rw %b rsrc %b", ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_result_src); end
    checks++; if (ex_store_data !== 32'd3) begin errors++; $display("FAIL basic_store: got %h expected 3", ex_store_data); end
  endtask

  task automatic test_forward_priority();
    drive_id(1'b1, 32'h104, 32'h11, 32'h22, 32'd0, 5'd7, 5'd2, 5'd4, 1'b0, 3'b000, 1'b1, 1'b0, 2'b00);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_alu_result = 32'h100;
    memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_result = 32'h200;
    #1;
    checks++; if (alu_a !== 32'h100 || fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_exmem_wins: got a %h sel %b expected 100 10", alu_a, fwd_a); end
    checks++; if (alu_b !== 32'h22 || fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_rs2_untouched: got b %h sel %b expected 22 00", alu_b, fwd_b); end
    exmem_reg_write = 1'b0;
    #1;
    checks++; if (alu_a !== 32'h200 || fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_memwb: got a %h sel %b expected 200 01", alu_a, fwd_a); end
    memwb_reg_write = 1'b0;
    #1;
    checks++; if (alu_a !== 32'h11 || fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_none: got a %h sel %b expected 11 00", alu_a, fwd_a); end
    clear_fwd();
  endtask

  task automatic test_x0();
    drive_id(1'b1, 32'h108, 32'h55, 32'h33, 32'd0, 5'd0, 5'd0, 5'd5, 1'b0, 3'b011, 1'b1, 1'b0, 2'b00);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_alu_result = 32'hDEAD;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
    #1;
    checks++; if (alu_b !== 32'h33 || fwd_b !== 2'b00) begin errors++; $display("FAIL x0_rs2: got b %h sel %b expected 33 00", alu_b, fwd_b); end
    checks++; if (alu_a !== 32'h55 || fwd_a !== 2'b00) begin errors++; $display("FAIL x0_rs1: got a %h sel %b expected 55 00", alu_a, fwd_a); end
    clear_fwd();
  endtask

  task automatic test_imm();
    drive_id(1'b1, 32'h10C, 32'h1, 32'h44, 32'hFFFFFFFC, 5'd1, 5'd4, 5'd6, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00);
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'd9;
    tick();
    checks++; if (alu_b !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm_alu_b: got %h expected fffffffc", alu_b); end
    checks++; if (ex_store_data !== 32'd9 || fwd_b !== 2'b01) begin errors++; $display("FAIL imm_store: got %h sel %b expected 9 01", ex_store_data, fwd_b); end
    checks++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL imm_writes: got mw %b rw %b expected 1 0", ex_mem_write, ex_reg_write); end
    clear_fwd();
  endtask

  task automatic test_invalid_and_illegal();
    drive_id(1'b0, 32'h110, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b111, 1'b1, 1'b1, 2'b01);
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin errors++; $display("FAIL invalid_writes: valid %b rw %b mw %b expected 0 0 0", ex_valid, ex_reg_write, ex_mem_write); end
    checks++; if (alu_control !== 3'b111 || ex_pc !== 32'h110) begin errors++; $display("FAIL illegal_passthru: ctl %b pc %h expected 111 110", alu_control, ex_pc); end
  endtask

  task automatic test_stall_flush();
    drive_id(1'b1, 32'h200, 32'hA, 32'hB, 32'd0, 5'd3, 5'd5, 5'd9, 1'b0, 3'b010, 1'b1, 1'b1, 2'b01);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'h300 + 32'(i), 32'hF0, 32'hF1, 32'd7, 5'd10, 5'd11, 5'd12, 1'b1, 3'b101, 1'b0, 1'b0, 2'b10);
      tick();
      checks++; if (ex_pc !== 32'h200 || ex_rd !== 5'd9 || alu_control !== 3'b010 || alu_a !== 32'hA || alu_b !== 32'hB || ex_mem_write !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d: pc %h rd %0d ctl %b a %h b %h mw %b", i, ex_pc, ex_rd, alu_control, alu_a, alu_b, ex_mem_write); end
    end
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_alu_result = 32'h77;
    #1;
    checks++; if (alu_a !== 32'h77 || fwd_a !== 2'b10) begin errors++; $display("FAIL stall_fwd_live: got a %h sel %b expected 77 10", alu_a, fwd_a); end
    clear_fwd();
    flush = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin errors++; $display("FAIL flush_over_stall: valid %b rw %b mw %b expected 0 0 0", ex_valid, ex_reg_write, ex_mem_write); end
    checks++; if (ex_pc !== 32'd0 || alu_control !== 3'b000 || ex_rd !== 5'd0) begin errors++; $display("FAIL flush_bubble: pc %h ctl %b rd %0d expected 0", ex_pc, alu_control, ex_rd); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_id(1'b1, 32'h400, 32'h1, 32'h2, 32'd0, 5'd1, 5'd2, 5'd13, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got valid %b expected 1", ex_valid); end
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || alu_control !== 3'b000 || ex_pc !== 32'd0) begin errors++; $display("FAIL areset_immediate: valid %b ctl %b pc %h expected 0 000 0", ex_valid, alu_control, ex_pc); end
    stall = 1'b0;
    drive_id(1'b1, 32'h500, 32'h6, 32'h7, 32'd0, 5'd1, 5'd2, 5'd14, 1'b0, 3'b011, 1'b1, 1'b0, 2'b00);
    #2 rst_n = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h500 || alu_control !== 3'b011 || alu_a !== 32'h6) begin errors++; $display("FAIL areset_first_load: valid %b pc %h ctl %b a %h expected 1 500 011 6", ex_valid, ex_pc, alu_control, alu_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward_priority();
    test_x0();
    test_imm();
    test_invalid_and_illegal();
    test_stall_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-forwarding stage directly upstream of the 32-bit ALU in the RISC-V core. It captures decoded instruction fields from the decode stage, holds or bubbles them under hazard-unit control, and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's A, B and 3-bit control inputs, plus the control bits that travel with the instruction to EX/MEM.

## Interface
- No parameters; XLEN fixed at 32, register index width 5.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  instruction PC
- id_rs1_data, id_rs2_data  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_alu_src  in  1  0 = ALU B from rs2, 1 = ALU B from imm
- id_alu_control  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- id_reg_write, id_mem_write  in  1 each  write enables
- id_result_src  in  2  writeback select, passed through
- stall  in  1  hold the EX register
- flush  in  1  load a bubble into the EX register
- exmem_reg_write, exmem_rd, exmem_alu_result  in  1/5/32  EX/MEM forwarding source
- memwb_reg_write, memwb_rd, memwb_result  in  1/5/32  MEM/WB forwarding source
- alu_a, alu_b  out  32 each  ALU operands
- alu_control  out  3  ALU operation
- ex_valid, ex_reg_write, ex_mem_write  out  1 each
- ex_rd, ex_rs1, ex_rs2  out  5 each  (rs indices go to the hazard unit)
- ex_result_src  out  2
- ex_pc, ex_store_data  out  32 each
- fwd_a, fwd_b  out  2 each  forward select: 00 register, 10 EX/MEM, 01 MEM/WB

## Operation
- EX register fields: valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_src, alu_control, reg_write, mem_write, result_src.
- Each rising edge, in priority order:
  - flush: load a bubble (all fields 0).
  - else stall: hold every field.
  - else: load all id_* inputs.
- flush takes priority over stall when both are asserted.
- If id_valid = 0 on a load, reg_write and mem_write are forced to 0.
- Forwarding is combinational from registered rs1/rs2 and the live exmem/memwb inputs. For operand X ∈ {rs1, rs2}:
  - EX/MEM: exmem_reg_write & exmem_rd ≠ 0 & exmem_rd == X
  - else MEM/WB: memwb_reg_write & memwb_rd ≠ 0 & memwb_rd == X
  - else the registered data
- EX/MEM wins when both sources match. x0 is never forwarded.
- alu_a = forwarded rs1.
- ex_store_data = forwarded rs2.
- alu_b = imm when alu_src = 1, else forwarded rs2.
- fwd_b reports the rs2 selection even when alu_src = 1.
- alu_control and the other ex_* outputs come straight from the register.
- Illegal alu_control codes (100, 110, 111) pass through unmodified; the ALU then returns 0.
- While stalled, forwarding keeps re-evaluating against the current exmem/memwb inputs.
- Load-use detection is not done here. The hazard unit drives stall and flush.

## Timing
- Reset (asynchronous assert, synchronous-edge release): every register field is 0.
  - Therefore ex_valid = 0, ex_reg_write = 0, ex_mem_write = 0, alu_control = 000, ex_pc = 0, ex_rd/rs1/rs2 = 0.
  - fwd_a = fwd_b = 00 and alu_a = alu_b = 0, unless exmem/memwb sources match index 0, which is impossible because x0 is excluded.
- Latency: one cycle from id_* to ex_* outputs.
- Forwarded operands settle in the same cycle that the exmem/memwb inputs change. There is no registered path.
- Reset asserted mid-stall clears the register immediately. The first load after release is the id_* value present at that edge, unless stall or flush is asserted.

## Structure
- Shared package riscv_pkg holds:
  - ALU control constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Forward-select constants: FWD_REG, FWD_EXMEM, FWD_MEMWB.
  - Result-source encodings.
  - An id_ex_t struct for the register fields.
- Sub-module forward_mux, instantiated twice (rs1, rs2).
  - Inputs: index, register data, both forwarding sources.
  - Outputs: selected data and 2-bit select.

## Test plan
- Reset, then id_valid = 1, rs1_data = 5, rs2_data = 3, alu_control = 001, alu_src = 0, no forward match -> next cycle alu_a = 5, alu_b = 3, fwd_a = fwd_b = 00, ex_valid = 1.
- Registered rs1 = 7; exmem_reg_write = 1, exmem_rd = 7, exmem_alu_result = 0x100; memwb_reg_write = 1, memwb_rd = 7, memwb_result = 0x200 -> alu_a = 0x100, fwd_a = 10. Then drop exmem_reg_write -> alu_a = 0x200, fwd_a = 01.
- Registered rs2 = 0; exmem_rd = 0 with exmem_reg_write = 1 and exmem_alu_result = 0xDEAD -> alu_b = rs2_data, fwd_b = 00.
- alu_src = 1, imm = 0xFFFFFFFC, rs2 forwarded from MEM/WB value 9 -> alu_b = 0xFFFFFFFC, ex_store_data = 9, fwd_b = 01.
- stall = 1 for 3 cycles while id_* changes -> ex_* outputs are held. Then flush = 1 with stall = 1 -> next cycle ex_valid = 0, ex_reg_write = 0, ex_mem_write = 0.
- Assert rst_n low mid-cycle while ex_valid = 1 -> ex_valid = 0 and alu_control = 000 immediately, without waiting for a clock edge.
